// File: rtl/hs_deserializer.sv
// C-PHY slave HS deserializer: hunts for the sync word, then packs WORD_SYMS-symbol groups into flip/rotation/polarity words.
// Word and pulses are registered on the edge that samples the last symbol; there is no backpressure, so every edge consumes a symbol.
module hs_deserializer #(
  parameter int WORD_SYMS = 7,
  parameter logic [3*WORD_SYMS-1:0] SYNC_PATTERN = 21'b011_100_100_100_100_100_011
) (
  input  logic                 RxSymbolClkHS,
  input  logic                 RstN,
  input  logic                 HsDeserializerEn,
  input  logic [2:0]           SymIn,
  output logic [WORD_SYMS-1:0] RxFlip,
  output logic [WORD_SYMS-1:0] RxRotation,
  output logic [WORD_SYMS-1:0] RxPolarity,
  output logic                 RxWordValid,
  output logic                 SyncDet,
  output logic                 Locked
);

  localparam int SW = 3 * WORD_SYMS;
  localparam int CW = (WORD_SYMS > 1) ? $clog2(WORD_SYMS) : 1;

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  state_t              state, stateNext;
  logic [SW-4:0]       shiftReg, shiftNext;
  logic [CW-1:0]       cnt, cntNext;
  logic [SW-1:0]       cand;
  logic                isSync, lastSym;
  logic                wordValidNext, syncDetNext, captureWord;
  logic [WORD_SYMS-1:0] flipCand, rotCand, polCand;

  assign cand    = {shiftReg, SymIn};
  assign isSync  = (cand == SYNC_PATTERN);
  assign lastSym = (cnt == CW'(WORD_SYMS - 1));

  // First symbol of the word sits in the top bits of cand and lands in the top bit of each word
  always_comb begin
    flipCand = '0;
    rotCand  = '0;
    polCand  = '0;
    for (int j = 0; j < WORD_SYMS; j++) begin
      flipCand[j] = cand[3*j+2];
      rotCand[j]  = cand[3*j+1];
      polCand[j]  = cand[3*j];
    end
  end

  always_ff @(posedge RxSymbolClkHS or negedge RstN) begin
    if (!RstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (!HsDeserializerEn) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    stateNext = HUNT;
        HUNT:    if (isSync) stateNext = LOCKED;
        LOCKED:  stateNext = LOCKED;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    shiftNext     = shiftReg;
    cntNext       = cnt;
    wordValidNext = 1'b0;
    syncDetNext   = 1'b0;
    captureWord   = 1'b0;
    if (!HsDeserializerEn) begin
      shiftNext = '0;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          shiftNext = '0;
          cntNext   = '0;
        end
        HUNT: begin
          shiftNext = cand[SW-4:0];
          cntNext   = '0;
          syncDetNext = isSync;
        end
        LOCKED: begin
          shiftNext = cand[SW-4:0];
          if (lastSym) begin
            cntNext = '0;
            // An aligned sync word re-synchronises instead of being delivered as data
            if (isSync) begin
              syncDetNext = 1'b1;
            end else begin
              wordValidNext = 1'b1;
              captureWord   = 1'b1;
            end
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
        default: begin
          shiftNext = '0;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge RxSymbolClkHS or negedge RstN) begin
    if (!RstN) begin
      shiftReg    <= '0;
      cnt         <= '0;
      RxFlip      <= '0;
      RxRotation  <= '0;
      RxPolarity  <= '0;
      RxWordValid <= 1'b0;
      SyncDet     <= 1'b0;
    end else begin
      shiftReg    <= shiftNext;
      cnt         <= cntNext;
      RxWordValid <= wordValidNext;
      SyncDet     <= syncDetNext;
      if (captureWord) begin
        RxFlip     <= flipCand;
        RxRotation <= rotCand;
        RxPolarity <= polCand;
      end
    end
  end

  assign Locked = (state == LOCKED);

endmodule
